// File: rtl/hv_fetch_scheduler.sv
// Fetch scheduler for the spatial encoder: walks modality 1..3 and channel 0..CHANNELS-1,
// issues one read per slot to that modality's three SRAMs and hands the slot on once all valids are seen.
module hv_fetch_scheduler #(
   parameter int CHANNELS   = 16,
   parameter int ADDR_WIDTH = 4,
   parameter int TIMEOUT    = 255
) (
   input  logic                  Clk_CI,
   input  logic                  Reset_RI,
   input  logic                  ValidIn_SI,
   output logic                  ReadyOut_SO,
   output logic [2:0]            ReqMod_SO,
   output logic [ADDR_WIDTH-1:0] addr_mod1,
   output logic [ADDR_WIDTH-1:0] addr_mod2,
   output logic [ADDR_WIDTH-1:0] addr_mod3,
   input  logic [2:0]            SramValid_mod1_SI,
   input  logic [2:0]            SramValid_mod2_SI,
   input  logic [2:0]            SramValid_mod3_SI,
   output logic                  ChanValid_SO,
   input  logic                  ChanReady_SI,
   output logic [1:0]            ModSel_SO,
   output logic [ADDR_WIDTH-1:0] ChanIdx_DO,
   output logic                  LastChan_SO,
   output logic                  Done_SO,
   output logic                  Error_SO
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_CHAN   = ADDR_WIDTH'(CHANNELS - 1);
   localparam logic [TW-1:0]         TIMEOUT_VAL = TW'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DELIVER
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            mod_q, mod_d;
   logic [ADDR_WIDTH-1:0] chan_q, chan_d;
   logic [2:0]            sticky_q, sticky_d;
   logic [TW-1:0]         count_q, count_d;
   logic [2:0]            incoming;

   // Only the modality that was actually requested may contribute valids.
   always_comb begin
      case (mod_q)
         2'd1:    incoming = SramValid_mod1_SI;
         2'd2:    incoming = SramValid_mod2_SI;
         2'd3:    incoming = SramValid_mod3_SI;
         default: incoming = 3'b000;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      mod_d        = mod_q;
      chan_d       = chan_q;
      sticky_d     = sticky_q;
      count_d      = count_q;
      ReadyOut_SO  = 1'b0;
      ReqMod_SO    = 3'b000;
      ChanValid_SO = 1'b0;
      Done_SO      = 1'b0;
      Error_SO     = 1'b0;
      ModSel_SO    = mod_q;
      ChanIdx_DO   = chan_q;
      LastChan_SO  = (mod_q == 2'd3) && (chan_q == LAST_CHAN);

      case (state_q)
         ST_IDLE: begin
            ReadyOut_SO = 1'b1;
            ModSel_SO   = 2'd0;
            ChanIdx_DO  = '0;
            LastChan_SO = 1'b0;
            if (ValidIn_SI) begin
               state_d = ST_ISSUE;
               mod_d   = 2'd1;
               chan_d  = '0;
            end
         end
         ST_ISSUE: begin
            case (mod_q)
               2'd1:    ReqMod_SO = 3'b001;
               2'd2:    ReqMod_SO = 3'b010;
               2'd3:    ReqMod_SO = 3'b100;
               default: ReqMod_SO = 3'b000;
            endcase
            sticky_d = 3'b000;
            count_d  = '0;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            sticky_d = sticky_q | incoming;
            // A complete set of valids wins over a timeout landing in the same cycle.
            if ((sticky_q | incoming) == 3'b111) begin
               state_d = ST_DELIVER;
            end else if (count_q == TIMEOUT_VAL) begin
               Error_SO = 1'b1;
               state_d  = ST_IDLE;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         ST_DELIVER: begin
            ChanValid_SO = 1'b1;
            if (ChanReady_SI) begin
               if (chan_q != LAST_CHAN) begin
                  chan_d  = chan_q + 1'b1;
                  state_d = ST_ISSUE;
               end else if (mod_q != 2'd3) begin
                  mod_d   = mod_q + 1'b1;
                  chan_d  = '0;
                  state_d = ST_ISSUE;
               end else begin
                  Done_SO = 1'b1;
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Addresses are loaded on the way into ISSUE and then held until that modality is reissued.
   always_ff @(posedge Clk_CI or posedge Reset_RI) begin
      if (Reset_RI) begin
         state_q   <= ST_IDLE;
         mod_q     <= 2'd0;
         chan_q    <= '0;
         sticky_q  <= 3'b000;
         count_q   <= '0;
         addr_mod1 <= '0;
         addr_mod2 <= '0;
         addr_mod3 <= '0;
      end else begin
         state_q  <= state_d;
         mod_q    <= mod_d;
         chan_q   <= chan_d;
         sticky_q <= sticky_d;
         count_q  <= count_d;
         if (state_d == ST_ISSUE) begin
            case (mod_d)
               2'd1:    addr_mod1 <= chan_d;
               2'd2:    addr_mod2 <= chan_d;
               2'd3:    addr_mod3 <= chan_d;
               default: ;
            endcase
         end
      end
   end

endmodule
